// File: rtl/ball_collision_responder_pkg.sv
// ball_pkg: shared sizes, wall encodings, velocity type and responder state enum
package ball_pkg;
  localparam int NUM_BALLS = 2;
  localparam int VEL_W = 11;
  localparam int BALL_ID_W = 4;
  localparam int IDX_W = $clog2(NUM_BALLS + 1);
  localparam logic [1:0] WALL_NONE = 2'b00;
  localparam logic [1:0] WALL_X = 2'b01;
  localparam logic [1:0] WALL_Y = 2'b10;
  localparam logic [1:0] WALL_CORNER = 2'b11;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [2:0] {IDLE, WALL, PAIR, FRIC, HOLE} resp_state_t;
  function automatic logic valid_id(input logic [BALL_ID_W-1:0] id);
    return id <= BALL_ID_W'(NUM_BALLS);
  endfunction
endpackage

// File: rtl/ball_collision_responder_if.sv
// ball_collision_responder_if: collision events, cue shot and per-ball velocity outputs
interface ball_collision_responder_if;
  import ball_pkg::*;
  logic startOfFrame;
  logic [NUM_BALLS:0] balls_in_game;
  logic [NUM_BALLS:0] balls_collide;
  logic [1:0][BALL_ID_W-1:0] Balls_col_ID;
  logic [NUM_BALLS:0] ballwall_collide;
  logic [1:0] collided_wall;
  logic shot_valid;
  vel_t shot_vx;
  vel_t shot_vy;
  logic shot_ready;
  vel_t vx [NUM_BALLS+1];
  vel_t vy [NUM_BALLS+1];
  logic [NUM_BALLS:0] moving;
  logic busy;
  modport master (
    output startOfFrame, balls_in_game, balls_collide, Balls_col_ID, ballwall_collide,
           collided_wall, shot_valid, shot_vx, shot_vy,
    input  shot_ready, vx, vy, moving, busy
  );
  modport slave (
    input  startOfFrame, balls_in_game, balls_collide, Balls_col_ID, ballwall_collide,
           collided_wall, shot_valid, shot_vx, shot_vy,
    output shot_ready, vx, vy, moving, busy
  );
endinterface

// File: rtl/ball_collision_responder_vel_step.sv
// vel_step: saturating negate (mode 0) or one step toward zero (mode 1) of a velocity
module vel_step import ball_pkg::*; (
  input  logic i_en,
  input  logic i_mode,
  input  vel_t i_v,
  output vel_t o_v
);
  localparam vel_t VMIN = vel_t'({1'b1, {(VEL_W-1){1'b0}}});
  vel_t w_neg, w_step;
  always_comb begin
    w_neg = (i_v == VMIN) ? ~VMIN : -i_v;
    w_step = (i_v == '0) ? i_v : i_v[VEL_W-1] ? i_v + vel_t'(1) : i_v - vel_t'(1);
    o_v = !i_en ? i_v : i_mode ? w_step : w_neg;
  end
endmodule

// File: rtl/ball_collision_responder.sv
// ball_collision_responder: owns ball velocities, applies latched wall/pair/hole events each frame.
// Define FRICTION_EN to add a one-step decay toward zero every FRIC_DIV frames.
module ball_collision_responder import ball_pkg::*; #(
  parameter int WALL_COOLDOWN = 3
`ifdef FRICTION_EN
  , parameter int FRIC_DIV = 4
`endif
) (
  input logic clk,
  input logic resetN,
  ball_collision_responder_if.slave bus
);
  localparam int CD_W = $clog2(WALL_COOLDOWN + 1);
  localparam idx_t LAST = idx_t'(NUM_BALLS);
  resp_state_t r_state, w_next_state;
  idx_t r_idx, w_next_idx;
  vel_t r_vx [NUM_BALLS+1];
  vel_t r_vy [NUM_BALLS+1];
  logic [CD_W-1:0] r_cd [NUM_BALLS+1];
  logic [1:0] r_pend_wall [NUM_BALLS+1];
  logic [1:0] w_pend_next [NUM_BALLS+1];
  logic r_pair_v;
  idx_t r_pair_a, r_pair_b;
  logic [NUM_BALLS:0] r_moving;
  logic r_shot_ready, r_busy;
  logic w_last, w_pair_latch, w_shot, w_mode, w_refl, w_en_x, w_en_y, w_fric_tick;
  logic [BALL_ID_W-1:0] w_id0, w_id1;
  vel_t w_vx, w_vy;
`ifdef FRICTION_EN
  localparam int FC_W = $clog2(FRIC_DIV + 1);
  logic [FC_W-1:0] r_fric_cnt;
  assign w_fric_tick = r_fric_cnt == FC_W'(FRIC_DIV - 1);
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) r_fric_cnt <= '0;
    else if (r_state == FRIC && w_last) r_fric_cnt <= w_fric_tick ? '0 : r_fric_cnt + 1'b1;
`else
  assign w_fric_tick = 1'b0;
`endif
  assign w_last = r_idx == LAST;
  always_comb begin
    w_next_state = r_state;
    w_next_idx = w_last ? '0 : r_idx + 1'b1;
    case (r_state)
      IDLE: begin
        w_next_state = bus.startOfFrame ? WALL : IDLE;
        w_next_idx = '0;
      end
      WALL: w_next_state = w_last ? PAIR : WALL;
      PAIR: begin
`ifdef FRICTION_EN
        w_next_state = FRIC;
`else
        w_next_state = HOLE;
`endif
        w_next_idx = '0;
      end
      FRIC: w_next_state = w_last ? HOLE : FRIC;
      HOLE: w_next_state = w_last ? IDLE : HOLE;
      default: w_next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state <= IDLE;
      r_idx <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx <= w_next_idx;
    end
  always_comb begin
    w_id0 = bus.Balls_col_ID[0];
    w_id1 = bus.Balls_col_ID[1];
    w_pair_latch = |bus.balls_collide && !r_pair_v && w_id0 != w_id1 && valid_id(w_id0) && valid_id(w_id1);
    w_shot = r_state == IDLE && bus.shot_valid && bus.balls_in_game[0] && !bus.startOfFrame;
    w_mode = r_state == FRIC;
    w_refl = r_state == WALL && r_pend_wall[r_idx] != WALL_NONE;
    w_en_x = w_mode ? w_fric_tick : r_state == WALL && |(r_pend_wall[r_idx] & WALL_X);
    w_en_y = w_mode ? w_fric_tick : r_state == WALL && |(r_pend_wall[r_idx] & WALL_Y);
    for (int i = 0; i <= NUM_BALLS; i++)
      // a reflecting or pocketed ball discards any wall event arriving in the same cycle
      w_pend_next[i] = (r_idx == idx_t'(i) && (w_refl || (r_state == HOLE && !bus.balls_in_game[i]))) ? WALL_NONE :
                       r_pend_wall[i] | ((bus.ballwall_collide[i] && r_cd[i] == '0) ? bus.collided_wall : WALL_NONE);
  end
  vel_step u_step_x (.i_en(w_en_x), .i_mode(w_mode), .i_v(r_vx[r_idx]), .o_v(w_vx));
  vel_step u_step_y (.i_en(w_en_y), .i_mode(w_mode), .i_v(r_vy[r_idx]), .o_v(w_vy));
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      for (int i = 0; i <= NUM_BALLS; i++) begin
        r_vx[i] <= '0;
        r_vy[i] <= '0;
        r_cd[i] <= '0;
        r_pend_wall[i] <= WALL_NONE;
      end
      r_pair_v <= 1'b0;
      r_pair_a <= '0;
      r_pair_b <= '0;
      r_moving <= '0;
      r_shot_ready <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_shot_ready <= w_next_state == IDLE;
      r_busy <= w_next_state != IDLE;
      for (int i = 0; i <= NUM_BALLS; i++) begin
        r_pend_wall[i] <= w_pend_next[i];
        r_moving[i] <= r_vx[i] != '0 || r_vy[i] != '0;
      end
      if (w_pair_latch) begin
        r_pair_v <= 1'b1;
        r_pair_a <= w_id0[IDX_W-1:0];
        r_pair_b <= w_id1[IDX_W-1:0];
      end else if (r_state == PAIR) r_pair_v <= 1'b0;
      case (r_state)
        IDLE: if (w_shot) begin
          r_vx[0] <= bus.shot_vx;
          r_vy[0] <= bus.shot_vy;
        end
        WALL: begin
          r_vx[r_idx] <= w_vx;
          r_vy[r_idx] <= w_vy;
          if (w_refl) r_cd[r_idx] <= CD_W'(WALL_COOLDOWN);
          else if (r_cd[r_idx] != '0) r_cd[r_idx] <= r_cd[r_idx] - 1'b1;
        end
        PAIR: if (r_pair_v) begin
          r_vx[r_pair_a] <= r_vx[r_pair_b];
          r_vy[r_pair_a] <= r_vy[r_pair_b];
          r_vx[r_pair_b] <= r_vx[r_pair_a];
          r_vy[r_pair_b] <= r_vy[r_pair_a];
        end
        FRIC: begin
          r_vx[r_idx] <= w_vx;
          r_vy[r_idx] <= w_vy;
        end
        HOLE: if (!bus.balls_in_game[r_idx]) begin
          r_vx[r_idx] <= '0;
          r_vy[r_idx] <= '0;
        end
        default: ;
      endcase
    end
  assign bus.vx = r_vx;
  assign bus.vy = r_vy;
  assign bus.moving = r_moving;
  assign bus.shot_ready = r_shot_ready;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_ball_collision_responder.sv
// tb_ball_collision_responder: directed checks of wall, pair, friction, hole, shot and reset behaviour
module tb_ball_collision_responder;
  import ball_pkg::*;
  logic clk = 1'b0;
  logic resetN = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  ball_collision_responder_if bus();
  ball_collision_responder dut (.clk(clk), .resetN(resetN), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.startOfFrame = 1'b0;
    bus.balls_in_game = 3'b111;
    bus.balls_collide = '0;
    bus.Balls_col_ID = '0;
    bus.ballwall_collide = '0;
    bus.collided_wall = WALL_NONE;
    bus.shot_valid = 1'b0;
    bus.shot_vx = '0;
    bus.shot_vy = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    for (int k = 0; k < 40 && bus.busy; k++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL frame_end busy=%b want 0", bus.busy); end
  endtask

  task automatic shot(input int x, input int y);
    @(negedge clk);
    bus.shot_valid = 1'b1;
    bus.shot_vx = vel_t'(x);
    bus.shot_vy = vel_t'(y);
    @(negedge clk);
    bus.shot_valid = 1'b0;
  endtask

  task automatic wall_evt(input logic [NUM_BALLS:0] m, input logic [1:0] w);
    @(negedge clk);
    bus.ballwall_collide = m;
    bus.collided_wall = w;
    @(negedge clk);
    bus.ballwall_collide = '0;
    bus.collided_wall = WALL_NONE;
  endtask

  task automatic pair_evt(input logic [BALL_ID_W-1:0] a, input logic [BALL_ID_W-1:0] b);
    @(negedge clk);
    bus.balls_collide = 3'b011;
    bus.Balls_col_ID[0] = a;
    bus.Balls_col_ID[1] = b;
    @(negedge clk);
    bus.balls_collide = '0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    @(negedge clk);
    for (int i = 0; i <= NUM_BALLS; i++) begin
      n_cmp++;
      if (bus.vx[i] !== vel_t'(0) || bus.vy[i] !== vel_t'(0)) begin
        n_err++; $display("FAIL reset_vel[%0d] got %0d,%0d want 0,0", i, bus.vx[i], bus.vy[i]);
      end
    end
    n_cmp++;
    if (bus.moving !== 3'b000) begin n_err++; $display("FAIL reset_moving got %b want 000", bus.moving); end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.shot_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_flags busy=%b ready=%b want 0 1", bus.busy, bus.shot_ready);
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wall();
    do_reset();
    shot(5, -3);
    n_cmp++;
    if (bus.vx[0] !== vel_t'(5) || bus.vy[0] !== vel_t'(-3)) begin
      n_err++; $display("FAIL shot_load got %0d,%0d want 5,-3", bus.vx[0], bus.vy[0]);
    end
    wall_evt(3'b001, WALL_X);
    frame();
    n_cmp++;
    if (bus.vx[0] !== vel_t'(-5) || bus.vy[0] !== vel_t'(-3)) begin
      n_err++; $display("FAIL wall_x got %0d,%0d want -5,-3", bus.vx[0], bus.vy[0]);
    end
    n_cmp++;
    if (bus.moving !== 3'b001) begin n_err++; $display("FAIL wall_moving got %b want 001", bus.moving); end
    for (int f = 0; f < 2; f++) begin
      wall_evt(3'b001, WALL_X);
      frame();
      n_cmp++;
      if (bus.vx[0] !== vel_t'(-5)) begin n_err++; $display("FAIL wall_cooldown%0d got %0d want -5", f, bus.vx[0]); end
    end
    do_reset();
    shot(4, 4);
    wall_evt(3'b001, WALL_Y);
    frame();
    n_cmp++;
    if (bus.vx[0] !== vel_t'(4) || bus.vy[0] !== vel_t'(-4)) begin
      n_err++; $display("FAIL wall_y got %0d,%0d want 4,-4", bus.vx[0], bus.vy[0]);
    end
  endtask

  task automatic test_corner();
    do_reset();
    shot(-1024, 7);
    wall_evt(3'b001, WALL_CORNER);
    frame();
    n_cmp++;
    if (bus.vx[0] !== vel_t'(1023) || bus.vy[0] !== vel_t'(-7)) begin
      n_err++; $display("FAIL corner_sat got %0d,%0d want 1023,-7", bus.vx[0], bus.vy[0]);
    end
  endtask

  task automatic test_pair();
    do_reset();
    shot(6, 0);
    pair_evt(4'd0, 4'd1);
    pair_evt(4'd1, 4'd2);
    frame();
    n_cmp++;
    if (bus.vx[0] !== vel_t'(0) || bus.vx[1] !== vel_t'(6) || bus.vx[2] !== vel_t'(0)) begin
      n_err++; $display("FAIL pair_swap got %0d,%0d,%0d want 0,6,0", bus.vx[0], bus.vx[1], bus.vx[2]);
    end
    n_cmp++;
    if (bus.moving !== 3'b010) begin n_err++; $display("FAIL pair_moving got %b want 010", bus.moving); end
    pair_evt(4'd2, 4'd2);
    frame();
    n_cmp++;
    if (bus.vx[1] !== vel_t'(6) || bus.vx[2] !== vel_t'(0)) begin
      n_err++; $display("FAIL pair_same_id got %0d,%0d want 6,0", bus.vx[1], bus.vx[2]);
    end
    pair_evt(4'd5, 4'd0);
    frame();
    n_cmp++;
    if (bus.vx[0] !== vel_t'(0) || bus.vx[1] !== vel_t'(6)) begin
      n_err++; $display("FAIL pair_bad_id got %0d,%0d want 0,6", bus.vx[0], bus.vx[1]);
    end
  endtask

  task automatic test_friction();
    do_reset();
    shot(3, 0);
    for (int f = 1; f <= 12; f++) begin
      frame();
`ifdef FRICTION_EN
      if (f % 4 == 0) begin
        n_cmp++;
        if (bus.vx[0] !== vel_t'(3 - f / 4)) begin
          n_err++; $display("FAIL fric_f%0d got %0d want %0d", f, bus.vx[0], 3 - f / 4);
        end
      end
`endif
    end
`ifdef FRICTION_EN
    n_cmp++;
    if (bus.moving[0] !== 1'b0) begin n_err++; $display("FAIL fric_moving got %b want 0", bus.moving[0]); end
`else
    n_cmp++;
    if (bus.vx[0] !== vel_t'(3) || bus.moving[0] !== 1'b1) begin
      n_err++; $display("FAIL no_fric got %0d/%b want 3/1", bus.vx[0], bus.moving[0]);
    end
`endif
  endtask

  task automatic test_hole_shot_gate();
    do_reset();
    shot(6, 2);
    pair_evt(4'd0, 4'd1);
    frame();
    n_cmp++;
    if (bus.vx[1] !== vel_t'(6) || bus.vy[1] !== vel_t'(2)) begin
      n_err++; $display("FAIL hole_setup got %0d,%0d want 6,2", bus.vx[1], bus.vy[1]);
    end
    bus.balls_in_game = 3'b101;
    frame();
    n_cmp++;
    if (bus.vx[1] !== vel_t'(0) || bus.vy[1] !== vel_t'(0) || bus.moving[1] !== 1'b0) begin
      n_err++; $display("FAIL hole_zero got %0d,%0d/%b want 0,0/0", bus.vx[1], bus.vy[1], bus.moving[1]);
    end
    bus.balls_in_game = 3'b111;
    do_reset();
    shot(5, 5);
    bus.balls_in_game = 3'b110;
    shot(9, 9);
    n_cmp++;
    if (bus.vx[0] !== vel_t'(5) || bus.vy[0] !== vel_t'(5)) begin
      n_err++; $display("FAIL shot_gate got %0d,%0d want 5,5", bus.vx[0], bus.vy[0]);
    end
    bus.balls_in_game = 3'b111;
  endtask

  task automatic test_reset_mid_pass();
    do_reset();
    shot(7, 1);
    pair_evt(4'd0, 4'd1);
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.vx[0] !== vel_t'(7)) begin
      n_err++; $display("FAIL mid_pass busy=%b vx0=%0d want 1 7", bus.busy, bus.vx[0]);
    end
    resetN = 1'b0;
    #1;
    n_cmp++;
    if (bus.vx[0] !== vel_t'(0) || bus.vy[0] !== vel_t'(0) || bus.vx[1] !== vel_t'(0)) begin
      n_err++; $display("FAIL abort_vel got %0d,%0d,%0d want 0,0,0", bus.vx[0], bus.vy[0], bus.vx[1]);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.shot_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_flags busy=%b ready=%b want 0 1", bus.busy, bus.shot_ready);
    end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    shot(4, 0);
    frame();
    n_cmp++;
    if (bus.vx[0] !== vel_t'(4) || bus.vx[1] !== vel_t'(0)) begin
      n_err++; $display("FAIL abort_pair_cleared got %0d,%0d want 4,0", bus.vx[0], bus.vx[1]);
    end
  endtask

  task automatic test_shot_frame_collision();
    do_reset();
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    bus.shot_valid = 1'b1;
    bus.shot_vx = vel_t'(8);
    bus.shot_vy = vel_t'(0);
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.shot_valid = 1'b0;
    n_cmp++;
    if (bus.shot_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL coincide_flags ready=%b busy=%b want 0 1", bus.shot_ready, bus.busy);
    end
    for (int k = 0; k < 40 && bus.busy; k++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.vx[0] !== vel_t'(0) || bus.shot_ready !== 1'b1) begin
      n_err++; $display("FAIL coincide_drop vx0=%0d ready=%b want 0 1", bus.vx[0], bus.shot_ready);
    end
    shot(8, 0);
    n_cmp++;
    if (bus.vx[0] !== vel_t'(8)) begin n_err++; $display("FAIL coincide_retry got %0d want 8", bus.vx[0]); end
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_wall();
    test_corner();
    test_pair();
    test_friction();
    test_hole_shot_gate();
    test_reset_mid_pass();
    test_shot_frame_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ball_collision_responder.md
Name: ball_collision_responder

Overview:
- Consumes the per-frame collision pulses from the game controller: ball–wall (ballwall_collide, collided_wall), ball–ball (balls_collide, Balls_col_ID) and ball–hole (balls_in_game).
- Owns every ball's signed velocity and accepts a cue shot for ball 0.
- At each startOfFrame it applies the latched events and optional friction, then presents updated velocities to the ball movement blocks.

Parameters:
- NUM_BALLS, 2, highest ball index; the block handles NUM_BALLS+1 balls and ball 0 is the white ball.
- VEL_W, 11, signed velocity width in pixels per frame, fixed point as used by the movement blocks.
- WALL_COOLDOWN, 3, number of frames during which further wall events for a ball are ignored after a reflection.
- FRIC_DIV, 4, friction applies once every FRIC_DIV frames.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per frame
- balls_in_game  in  NUM_BALLS+1  1 = ball still on the table
- balls_collide  in  NUM_BALLS+1  one-cycle pulse: ball–ball event
- Balls_col_ID  in  2x4  indices of the two colliding balls, valid with balls_collide
- ballwall_collide  in  NUM_BALLS+1  one-cycle pulse: ball–wall event
- collided_wall  in  2  01 = left/right wall, 10 = top/bottom wall, 11 = corner, 00 = none
- shot_valid  in  1  cue shot request for ball 0
- shot_vx, shot_vy  in  VEL_W each, signed  shot velocity
- shot_ready  out  1  high while the FSM is in IDLE
- vx, vy  out  (NUM_BALLS+1)xVEL_W, signed  per-ball velocity
- moving  out  NUM_BALLS+1  1 = the ball's vx or vy is nonzero
- busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset:
  - all vx/vy = 0, moving = 0, busy = 0, shot_ready = 1, FSM = IDLE.
  - all pending flags and cooldown counters cleared; friction counter = 0.
- Event latching runs in every state, in the same cycle as the pulse:
  - Wall: for each ball with ballwall_collide[i]=1 and wall cooldown = 0, pend_wall[i] |= collided_wall.
  - Pair: on balls_collide≠0, if no pair is pending, IDs differ and both IDs ≤ NUM_BALLS, latch pend_pair = {id0, id1}. Otherwise drop the event.
- FSM states: IDLE, WALL, PAIR, FRIC, HOLE. Each state advances one ball index per clock.
  - IDLE: a startOfFrame pulse moves to WALL with index 0. A startOfFrame pulse outside IDLE is ignored, because a full pass takes at most 3(NUM_BALLS+1)+1 cycles.
  - WALL, for ball i:
    - bit0 of pend_wall negates vx; bit1 negates vy.
    - Negation saturates: the most negative value maps to the most positive value.
    - If any bit was set, reload the cooldown counter with WALL_COOLDOWN and clear pend_wall[i]; otherwise decrement a nonzero cooldown.
    - After the last ball, go to PAIR.
  - PAIR: one cycle. If a pair is pending, exchange the {vx,vy} of the two balls (equal-mass head-on model) and clear pend_pair. Go to FRIC.
  - FRIC, for ball i:
    - If the friction counter = FRIC_DIV-1, each nonzero component moves 1 toward 0.
    - The counter advances once per pass, wrapping at FRIC_DIV-1→0.
    - Go to HOLE.
  - HOLE, for ball i: if balls_in_game[i]=0, force vx=vy=0 and clear its pending wall flag. After the last ball, return to IDLE.
- Shot:
  - Accepted only when shot_valid=1 in IDLE and balls_in_game[0]=1.
  - vx[0], vy[0] are loaded the next cycle.
  - A startOfFrame in the same cycle has priority: the shot is not accepted, shot_ready stays 0 and the shot must be re-presented.
- Outputs are registered. moving is recomputed from vx/vy every cycle, one cycle behind them.
- A resetN assertion mid-pass aborts the pass immediately and restores all reset values.

Optional Feature:
- FRICTION_EN defined: the FRIC state behaves as described above.
- FRICTION_EN undefined:
  - the FRIC state and the friction counter are not generated.
  - PAIR goes directly to HOLE at index 0.
  - velocities persist until a collision or a shot changes them.

Decomposition:
- Package ball_pkg holds:
  - NUM_BALLS, VEL_W, BALL_ID_W = 4.
  - wall encoding constants WALL_NONE/WALL_X/WALL_Y/WALL_CORNER.
  - typedef vel_t (signed VEL_W).
  - state enum resp_state_t.
- Sub-module vel_step: combinational saturating negate and step-toward-zero on one vel_t, with mode select. It is instanced for vx and vy.

Test Plan:
1. Wall reflection:
   - Stimulus: shot vx=5, vy=-3; in frame 1, ballwall_collide=001, collided_wall=01.
   - Required: after the pass vx0=-5, vy0=-3. A repeat event during the next 3 frames is ignored and vx0 stays -5.
2. Saturating corner:
   - Stimulus: vx0=-1024, vy0=7; corner event (collided_wall=11).
   - Required: vx0=1023, vy0=-7.
3. Ball–ball exchange:
   - Stimulus: ball0=(6,0), ball1=(0,0); balls_collide=011, Balls_col_ID={0,1}.
   - Required: ball0=(0,0), ball1=(6,0), moving=010. A second pair event before startOfFrame is dropped; invalid IDs {2,2} or {5,0} are dropped.
4. Friction (FRICTION_EN defined, FRIC_DIV=4):
   - Stimulus: vx0=3, no events.
   - Required: vx0 = 2, 1, 0 after frames 4, 8, 12; moving[0] clears afterwards. With FRICTION_EN undefined, vx0 stays 3.
5. Hole and shot gating:
   - Stimulus: ball1 moving, then balls_in_game=101; separately, shot_valid with balls_in_game[0]=0.
   - Required: vx1=vy1=0 after the pass; the shot is ignored with vx0 unchanged.
6. Reset mid-pass and shot/frame collision:
   - Stimulus: assert resetN=0 in the cycle the FSM is in PAIR; separately, assert shot_valid in the same cycle as startOfFrame.
   - Required: reset gives all velocities 0, FSM IDLE, busy=0. The coincident shot is not accepted and is accepted when re-presented in IDLE after the pass.
